prog_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 3-bit-opcode core (LDR, STR, MOV, XOR, AND, SHIFT, CMP, BR). It owns the program counter and steps each instruction through fetch, execute, optional data-memory access and commit. It gates the control decoder's write strobes through a single commit pulse. It sits between the top-level Start/Done handshake, the instruction ROM, the control decoder and the data memory.

---
 rtl/prog_sequencer.sv | 124 ++++++++++++
 tb/tb_prog_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and steps FETCH -> EXEC -> (MEM) -> WB.
// Optional memory-access timeout abort is enabled by defining SEQ_MEM_TIMEOUT_EN.
module prog_sequencer #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024,
    parameter int TIMEOUT  = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_opcode,
    input  logic            i_branch,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_mem_ack,
    output logic [PC_W-1:0] o_prog_ctr,
    output logic            o_ir_load,
    output logic            o_mem_req,
    output logic            o_commit_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [2:0]      o_state
);

    // Handshake: i_mem_ack is only honoured while in S_MEM (o_mem_req high); the
    // access completes on the rising edge where both are high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int NW = PC_W + 1;
    localparam logic [PC_W:0] C_LEN = NW'(PROG_LEN);

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W:0]   w_next_pc;
    logic            w_pc_clr;
    logic            w_pc_adv;
    logic            w_timeout;

    // One extra bit so the increment past all-ones terminates instead of wrapping.
    assign w_next_pc = (i_opcode == 3'b111 && i_branch) ? {1'b0, i_target}
                                                          : {1'b0, r_pc} + NW'(1);

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == S_MEM) && !i_mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_MEM) r_cnt <= '0;
            else if (!i_mem_ack)  r_cnt <= r_cnt + CNT_W'(1);
            if (w_pc_clr)        r_err <= 1'b0;
            else if (w_timeout)  r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_clr)      r_pc <= '0;
            else if (w_pc_adv) r_pc <= w_next_pc[PC_W-1:0];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_clr     = 1'b0;
        w_pc_adv     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                    w_pc_clr     = 1'b1;
                end
            end
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = (i_opcode[2:1] == 2'b00) ? S_MEM : S_WB;
            S_MEM: begin
                if (i_mem_ack)      w_next_state = S_WB;
                else if (w_timeout) w_next_state = S_DONE;
            end
            S_WB: begin
                if (w_next_pc >= C_LEN) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FETCH;
                    w_pc_adv     = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign o_prog_ctr  = r_pc;
    assign o_ir_load   = (r_state == S_FETCH);
    assign o_mem_req   = (r_state == S_MEM);
    assign o_commit_en = (r_state == S_WB);
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_state     = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a short-program instance (PROG_LEN=3) and a
// 16-word instance (PC_W=4) so the end-of-address-space case is reachable.
module tb_prog_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_DONE = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] opcode = 3'b010;
    logic       branch = 1'b0;
    logic [3:0] target = 4'd0;
    logic       mem_ack = 1'b0;

    logic [3:0] pc_a, pc_b;
    logic       ir_a, req_a, com_a, busy_a, done_a, err_a;
    logic       ir_b, req_b, com_b, busy_b, done_b, err_b;
    logic [2:0] st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    prog_sequencer #(.PC_W(4), .PROG_LEN(3), .TIMEOUT(15)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_opcode(opcode),
        .i_branch(branch), .i_target(target), .i_mem_ack(mem_ack),
        .o_prog_ctr(pc_a), .o_ir_load(ir_a), .o_mem_req(req_a), .o_commit_en(com_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_state(st_a)
    );

    prog_sequencer #(.PC_W(4), .PROG_LEN(16), .TIMEOUT(15)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_opcode(opcode),
        .i_branch(branch), .i_target(target), .i_mem_ack(mem_ack),
        .o_prog_ctr(pc_b), .o_ir_load(ir_b), .o_mem_req(req_b), .o_commit_en(com_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_state(st_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // Runs one instruction on dut_b starting at a FETCH-cycle negedge; returns at the
    // negedge after WB. n_ack=0 holds MemAck high throughout, else acks in MEM cycle n_ack.
    task automatic do_instr(input logic [2:0] op, input logic br, input logic [3:0] tgt,
                            input int n_ack, output int cyc, output int n_req,
                            output int n_com, output int ack_at, output int com_at);
        bit seen = 0;
        opcode = op; branch = br; target = tgt; mem_ack = (n_ack == 0);
        cyc = 0; n_req = 0; n_com = 0; ack_at = 0; com_at = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_b) begin
                n_req++;
                if (n_ack != 0) begin
                    mem_ack = (n_req == n_ack);
                    if (n_req == n_ack) ack_at = cyc;
                end
            end
            if (com_b) begin
                n_com++;
                com_at = cyc;
                seen = 1;
            end
        end
        check_eq("instr_bound", 32'(seen), 32'd1);
        @(negedge clk);
        cyc++;
        mem_ack = 1'b0;
    endtask

    task automatic step_instr(input string tag, input logic [2:0] op, input logic br,
                              input logic [3:0] tgt, input int n_ack, input int exp_cyc,
                              input int exp_req, input logic [3:0] exp_pc);
        int cyc, n_req, n_com, ack_at, com_at;
        do_instr(op, br, tgt, n_ack, cyc, n_req, n_com, ack_at, com_at);
        check_eq({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_req"}, 32'(n_req), 32'(exp_req));
        check_eq({tag, "_com"}, 32'(n_com), 32'd1);
        check_eq({tag, "_pc"}, 32'(pc_b), 32'(exp_pc));
        check_eq({tag, "_ir"}, 32'(ir_b), 32'd1);
    endtask

    initial begin
        int cyc, n_req, n_com, ack_at, com_at;

        // Reset for two cycles, then check the idle outputs of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state_a", 32'(st_a), 32'(ST_IDLE));
        check_eq("rst_outs_a", 32'({pc_a, ir_a, req_a, com_a, busy_a, done_a, err_a}), 32'd0);
        check_eq("rst_outs_b", 32'({pc_b, ir_b, req_b, com_b, busy_b, done_b, err_b}), 32'd0);

        // Three sequential instructions on the PROG_LEN=3 instance.
        reset = 1'b1; start_a = 1'b1; opcode = 3'b010;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            check_eq($sformatf("seq_ir_c%0d", c), 32'(ir_a), 32'(c == 1 || c == 4 || c == 7));
            check_eq($sformatf("seq_com_c%0d", c), 32'(com_a), 32'(c == 3 || c == 6 || c == 9));
            check_eq($sformatf("seq_done_c%0d", c), 32'(done_a), 32'(c == 10));
        end
        check_eq("seq_busy_end", 32'(busy_a), 32'd0);
        check_eq("seq_pc_end", 32'(pc_a), 32'd2);

        // Branch to Target == PROG_LEN terminates without moving the PC.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("brlen_restart_pc", 32'(pc_a), 32'd0);
        check_eq("brlen_restart_ir", 32'(ir_a), 32'd1);
        check_eq("brlen_restart_done", 32'(done_a), 32'd0);
        opcode = 3'b111; branch = 1'b1; target = 4'd3;
        @(negedge clk);
        @(negedge clk);
        check_eq("brlen_com", 32'(com_a), 32'd1);
        @(negedge clk);
        check_eq("brlen_done", 32'(done_a), 32'd1);
        check_eq("brlen_pc", 32'(pc_a), 32'd0);
        branch = 1'b0; target = 4'd0; opcode = 3'b010;

        // 16-word instance: branch to 5, then LDR with MemAck in the third MEM cycle.
        pulse_start_b();
        check_eq("b_start_ir", 32'(ir_b), 32'd1);
        check_eq("b_start_busy", 32'(busy_b), 32'd1);
        step_instr("br5", 3'b111, 1'b1, 4'd5, 1, 3, 0, 4'd5);
        do_instr(3'b000, 1'b0, 4'd0, 3, cyc, n_req, n_com, ack_at, com_at);
        check_eq("ldr_req_cycles", 32'(n_req), 32'd3);
        check_eq("ldr_total_cycles", 32'(cyc), 32'd6);
        check_eq("ldr_commit_after_ack", 32'(com_at - ack_at), 32'd1);
        check_eq("ldr_com", 32'(n_com), 32'd1);
        check_eq("ldr_pc", 32'(pc_b), 32'd6);

        // MemAck held high: ignored outside MEM, completes on MEM entry.
        step_instr("nop_ack", 3'b010, 1'b0, 4'd0, 0, 3, 0, 4'd7);
        step_instr("br_taken", 3'b111, 1'b1, 4'd2, 1, 3, 0, 4'd2);
        step_instr("br_to7", 3'b111, 1'b1, 4'd7, 1, 3, 0, 4'd7);
        step_instr("br_not_taken", 3'b111, 1'b0, 4'd2, 1, 3, 0, 4'd8);
        step_instr("cmp_branch_ign", 3'b110, 1'b1, 4'd2, 1, 3, 0, 4'd9);
        step_instr("str_ack_entry", 3'b001, 1'b0, 4'd0, 0, 4, 1, 4'd10);
        step_instr("br_self", 3'b111, 1'b1, 4'd10, 1, 3, 0, 4'd10);
        step_instr("br_top", 3'b111, 1'b1, 4'd15, 1, 3, 0, 4'd15);

        // Increment past all-ones ends the program instead of wrapping.
        do_instr(3'b010, 1'b0, 4'd0, 1, cyc, n_req, n_com, ack_at, com_at);
        check_eq("nowrap_done", 32'(done_b), 32'd1);
        check_eq("nowrap_state", 32'(st_b), 32'(ST_DONE));
        check_eq("nowrap_pc", 32'(pc_b), 32'd15);
        check_eq("nowrap_ir", 32'(ir_b), 32'd0);
        pulse_start_b();
        check_eq("restart_pc", 32'(pc_b), 32'd0);
        check_eq("restart_state", 32'(st_b), 32'(ST_FETCH));
        check_eq("restart_done", 32'(done_b), 32'd0);

        // Start during EXEC is ignored; reset in MEM drops MemReq on the next cycle.
        step_instr("nop_pc1", 3'b010, 1'b0, 4'd0, 1, 3, 0, 4'd1);
        opcode = 3'b000; mem_ack = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("start_exec_state", 32'(st_b), 32'(ST_MEM));
        check_eq("start_exec_pc", 32'(pc_b), 32'd1);
        check_eq("start_exec_req", 32'(req_b), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req", 32'(req_b), 32'd0);
        check_eq("rst_mem_busy", 32'(busy_b), 32'd0);
        check_eq("rst_mem_pc", 32'(pc_b), 32'd0);
        check_eq("rst_mem_state", 32'(st_b), 32'(ST_IDLE));
        reset = 1'b1;

        // STR whose MemAck never arrives.
        pulse_start_b();
        opcode = 3'b001; mem_ack = 1'b0;
        @(negedge clk);
        n_req = 0; n_com = 0;
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int c = 0; c < 40 && !done_b; c++) begin
            @(negedge clk);
            if (req_b) n_req++;
            if (com_b) n_com++;
        end
        check_eq("to_req_cycles", 32'(n_req), 32'd15);
        check_eq("to_err", 32'(err_b), 32'd1);
        check_eq("to_done", 32'(done_b), 32'd1);
        check_eq("to_no_commit", 32'(n_com), 32'd0);
        pulse_start_b();
        check_eq("to_err_clear", 32'(err_b), 32'd0);
        check_eq("to_restart_state", 32'(st_b), 32'(ST_FETCH));
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_b) n_req++;
            if (com_b) n_com++;
        end
        check_eq("wait_req_cycles", 32'(n_req), 32'd100);
        check_eq("wait_state", 32'(st_b), 32'(ST_MEM));
        check_eq("wait_err", 32'(err_b), 32'd0);
        check_eq("wait_no_commit", 32'(n_com), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
